// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the game score controller.
//   state_t      : game state encoding (IDLE=0, PLAY=1, WIN=2, OVER=3)
//   bcd_digit_t  : one 4-bit BCD digit
//   CODE_*       : status codes shown on display digit 7
//   BCD_MAX      : saturation value of the 4-digit score
//   bin_to_bcd2  : 0..99 binary to two BCD digits (kills display)
// Optional feature macro used by the design: SCORE_HISCORE_EN
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t  CODE_WIN     = 4'hA;
    localparam bcd_digit_t  CODE_OVER    = 4'hB;
    localparam bcd_digit_t  CODE_HISCORE = 4'hC;
    localparam logic [15:0] BCD_MAX      = 16'h9999;

    // Kill count never exceeds 99, so two digits always suffice.
    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] bin);
        logic [7:0] r;
        r[7:4] = 4'(bin / 7'd10);
        r[3:0] = 4'(bin % 7'd10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_add4.sv
// -----------------------------------------------------------------------------
// bcd_add4
// Combinational 4-digit BCD adder with saturation at 9999.
//   a_i   [15:0] : augend, 4 BCD digits
//   b_i   [15:0] : addend, 4 BCD digits
//   sum_o [15:0] : a_i + b_i in BCD, clamped to 16'h9999 on overflow
// -----------------------------------------------------------------------------
module bcd_add4
    import game_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);

    // Separate carry elements keep the ripple chain free of self-loops.
    logic        carry [0:4];
    logic [15:0] raw_sum;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [4:0] dsum;
            assign dsum = {1'b0, a_i[gi*4 +: 4]} + {1'b0, b_i[gi*4 +: 4]}
                        + {4'b0000, carry[gi]};
            assign carry[gi+1]        = (dsum > 5'd9);
            assign raw_sum[gi*4 +: 4] = carry[gi+1] ? 4'(dsum - 5'd10) : dsum[3:0];
        end
    endgenerate

    // A carry out of the top digit means the true sum exceeds 9999.
    assign sum_o = carry[4] ? BCD_MAX : raw_sum;

endmodule

// File: rtl/game_score_ctrl.sv
// -----------------------------------------------------------------------------
// game_score_ctrl
// Score, lives and display controller for a small shooter game.
// Parameters: NUM_ALIENS, START_LIVES, HIT_POINTS (BCD), PAGE_CYCLES.
// Ports:
//   clk, reset_n (synchronous, active-low)
//   start, alien_hit, player_hit : level inputs, rising edges act once
//   state [1:0], lives [2:0], score_bcd [15:0], hiscore_bcd [15:0]
//   disp_bcd [31:0] (digit 0 = [3:0]), disp_blank [7:0] (1 = digit off)
// Optional macro: SCORE_HISCORE_EN builds high-score tracking and the
// alternating hiscore page; without it hiscore_bcd is tied to 0.
// -----------------------------------------------------------------------------
module game_score_ctrl
    import game_pkg::*;
#(
    parameter int          NUM_ALIENS  = 15,
    parameter int          START_LIVES = 3,
    parameter logic [15:0] HIT_POINTS  = 16'h0010,
    parameter int          PAGE_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        alien_hit,
    input  logic        player_hit,
    output logic [1:0]  state,
    output logic [2:0]  lives,
    output logic [15:0] score_bcd,
    output logic [15:0] hiscore_bcd,
    output logic [31:0] disp_bcd,
    output logic [7:0]  disp_blank
);

    localparam logic [6:0] KILLS_WIN  = 7'(NUM_ALIENS);
    localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);

    logic start_q, alien_q, player_q;
    logic start_edge, alien_edge, player_edge;

    state_t      state_q, state_d;
    logic [2:0]  lives_q, lives_d;
    logic [15:0] score_q, score_d, score_inc;
    logic [6:0]  kills_q, kills_d;
    logic [31:0] disp_bcd_q, disp_bcd_d;
    logic [7:0]  disp_blank_q, disp_blank_d;
    logic [15:0] hiscore_view;
    logic        show_hi_page;

    assign start_edge  = start      & ~start_q;
    assign alien_edge  = alien_hit  & ~alien_q;
    assign player_edge = player_hit & ~player_q;

    bcd_add4 u_bcd_add4 (
        .a_i   (score_q),
        .b_i   (HIT_POINTS),
        .sum_o (score_inc)
    );

    // Game FSM plus score / kills / lives next-state.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        kills_d = kills_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                    kills_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            ST_PLAY: begin
                if (alien_edge) begin
                    score_d = score_inc;
                    kills_d = kills_q + 7'd1;
                end
                if (player_edge && (lives_q != 3'd0)) begin
                    lives_d = lives_q - 3'd1;
                end
                // Final kill wins even when the last life goes in the same cycle.
                if (kills_d == KILLS_WIN) begin
                    state_d = ST_WIN;
                end else if (lives_d == 3'd0) begin
                    state_d = ST_OVER;
                end
            end
            ST_WIN, ST_OVER: begin
                if (start_edge) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SCORE_HISCORE_EN
    logic [15:0] hiscore_q, hiscore_d;
    logic [31:0] timer_q, timer_d;
    logic        page_q, page_d;

    localparam logic [31:0] PAGE_LAST = 32'(PAGE_CYCLES - 1);

    always_comb begin
        hiscore_d = hiscore_q;
        // BCD digits order like binary, so a plain compare is a numeric compare.
        if ((state_q == ST_PLAY) && (state_d != ST_PLAY) && (score_d > hiscore_q)) begin
            hiscore_d = score_d;
        end
        // Timer and page restart on every state change; they only run while
        // staying in WIN or OVER.
        timer_d = '0;
        page_d  = 1'b0;
        if ((state_d == state_q) && ((state_q == ST_WIN) || (state_q == ST_OVER))) begin
            if (timer_q == PAGE_LAST) begin
                page_d = ~page_q;
            end else begin
                timer_d = timer_q + 32'd1;
                page_d  = page_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hiscore_q <= '0;
            timer_q   <= '0;
            page_q    <= 1'b0;
        end else begin
            hiscore_q <= hiscore_d;
            timer_q   <= timer_d;
            page_q    <= page_d;
        end
    end

    assign hiscore_view = hiscore_d;
    assign show_hi_page = page_d;
    assign hiscore_bcd  = hiscore_q;
`else
    assign hiscore_view = '0;
    assign show_hi_page = 1'b0;
    assign hiscore_bcd  = '0;
`endif

    // Display is built from next-state values so the registered digits line
    // up with the registered state/score on the same edge.
    always_comb begin
        disp_bcd_d   = '0;
        disp_blank_d = 8'hF0;
        unique case (state_d)
            ST_IDLE: begin
                disp_bcd_d[15:0] = hiscore_view;
            end
            ST_PLAY: begin
                disp_bcd_d   = {1'b0, lives_d, 4'h0, bin_to_bcd2(kills_d), score_d};
                disp_blank_d = 8'h40;
            end
            ST_WIN, ST_OVER: begin
                disp_blank_d = 8'h70;
                if (show_hi_page) begin
                    disp_bcd_d = {CODE_HISCORE, 12'h000, hiscore_view};
                end else begin
                    disp_bcd_d = {((state_d == ST_WIN) ? CODE_WIN : CODE_OVER), 12'h000, score_d};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_q      <= 1'b0;
            alien_q      <= 1'b0;
            player_q     <= 1'b0;
            state_q      <= ST_IDLE;
            lives_q      <= '0;
            score_q      <= '0;
            kills_q      <= '0;
            disp_bcd_q   <= '0;
            disp_blank_q <= 8'hF0;
        end else begin
            start_q      <= start;
            alien_q      <= alien_hit;
            player_q     <= player_hit;
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            kills_q      <= kills_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_blank_q <= disp_blank_d;
        end
    end

    assign state      = state_q;
    assign lives      = lives_q;
    assign score_bcd  = score_q;
    assign disp_bcd   = disp_bcd_q;
    assign disp_blank = disp_blank_q;

endmodule

// File: doc/game_score_ctrl.md
GAME_SCORE_CTRL -- requirements
Module: game_score_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  NUM_ALIENS   15        alien kills that end the game with WIN (1..99)
  START_LIVES  3         lives loaded at game start (1..7)
  HIT_POINTS   16'h0010  BCD points per alien kill (4 BCD digits)
  PAGE_CYCLES  50000000  cycles per display page in WIN/OVER
REQ-002 Ports SHALL be, one per line:
  clk          in   1   system clock, 100 MHz
  reset_n      in   1   reset, synchronous, active-low
  start        in   1   start/restart request, level
  alien_hit    in   1   alien destroyed, level, may be held multiple cycles
  player_hit   in   1   player destroyed, level, may be held multiple cycles
  state        out  2   game state: IDLE=0, PLAY=1, WIN=2, OVER=3
  lives        out  3   remaining lives, binary
  score_bcd    out  16  current score, 4 BCD digits
  hiscore_bcd  out  16  high score, 4 BCD digits
  disp_bcd     out  32  8 display digits, digit 0 = [3:0] = rightmost
  disp_blank   out  8   per-digit blank, 1 = digit off

Function
REQ-003 start, alien_hit and player_hit SHALL each be rising-edge detected against a registered copy of the input; a held level SHALL count once.
REQ-004 FSM: IDLE->PLAY on start edge; PLAY->WIN when kills reach NUM_ALIENS; PLAY->OVER when lives reach 0; WIN->IDLE and OVER->IDLE on start edge; no other transitions.
REQ-005 On the IDLE->PLAY edge: score_bcd=0, kills=0, lives=START_LIVES.
REQ-006 alien_hit edge in PLAY: score_bcd += HIT_POINTS (BCD arithmetic), kills += 1; the result SHALL be visible on the clock edge after the input is first sampled high.
REQ-007 Score SHALL saturate at 16'h9999 with no wrap.
REQ-008 player_hit edge in PLAY: lives -= 1; lives SHALL never go below 0.
REQ-009 Hit edges outside PLAY SHALL be ignored, with no change to score, kills or lives.
REQ-010 Simultaneous alien and player edges: both SHALL apply in the same cycle; if the final kill and the last life coincide, WIN SHALL take priority over OVER.
REQ-011 On entry to WIN or OVER: if score_bcd > hiscore_bcd, hiscore_bcd SHALL load score_bcd on the same edge as the state change.
REQ-012 A start edge in PLAY SHALL be ignored.
REQ-013 Display in IDLE: digits 3:0 = hiscore_bcd; digits 7:4 blanked.
REQ-014 Display in PLAY: digits 3:0 = score; digits 5:4 = kills in BCD; digit 6 blanked; digit 7 = lives.
REQ-015 Display in WIN/OVER: pages alternate every PAGE_CYCLES, starting with the score page.
  Score page: digits 3:0 = score; digit 7 = 4'hA for WIN or 4'hB for OVER.
  Hiscore page: digits 3:0 = hiscore_bcd; digit 7 = 4'hC.
  All other digits blanked on both pages.
  The page timer SHALL restart at 0 on each state entry.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 While reset_n is low at a clock edge, all of the following SHALL be zero: state (IDLE), score, hiscore, kills, lives, page timer and edge registers.
REQ-018 On reset, disp_blank SHALL be 8'hF0 and disp_bcd SHALL be 0.
REQ-019 Reset asserted mid-game SHALL abort to IDLE within one cycle and clear the high score.

Configuration
REQ-020 With SCORE_HISCORE_EN defined, high-score tracking and the hiscore page SHALL be built.
REQ-021 Without SCORE_HISCORE_EN, hiscore_bcd SHALL be constant 0, WIN/OVER SHALL show only the score page, and IDLE SHALL show 0000.

Structure
REQ-022 Package game_pkg SHALL hold: the state encoding, the 4-bit BCD digit type, the status codes 4'hA/4'hB/4'hC, and the BCD max 16'h9999.
REQ-023 Sub-module bcd_add4 SHALL be used: combinational 4-digit BCD adder with saturation.

Verification
REQ-024 Reset, then one start edge -> state=1, lives=3, score=0000.
REQ-025 alien_hit held high 10 cycles in PLAY -> score=0010 and kills=1 exactly once.
REQ-026 15 alien edges -> score=0150, state=2, hiscore=0150; disp digit 7 toggles A/C every PAGE_CYCLES.
REQ-027 Three player edges -> state=3; a further alien edge leaves score unchanged.
REQ-028 Lives=1, kills=14, alien and player edges in the same cycle -> state=2, lives=0.
REQ-029 HIT_POINTS=16'h5000, two kills -> score=9999 (saturated).
